updi_target_responder: RTL

//  Device-side UPDI responder: the far end of the programmer link; bench target model and FPGA-emulated chip.

---
 rtl/updi_target_pkg.sv | 52 +++++
 rtl/updi_target_cs_regs.sv | 50 +++++
 rtl/updi_target_responder.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/updi_target_pkg.sv
// UPDI target responder shared definitions: opcode/SYNCH/ACK constants, CS addresses, keys, FSM states.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package updi_target_pkg;

  localparam logic [7:0] SYNCH = 8'h55;
  localparam logic [7:0] ACK   = 8'h40;

  // Opcode high nibbles; the low nibble carries as/ds or the CS address.
  localparam logic [3:0] OPC_LDS  = 4'h0;
  localparam logic [3:0] OPC_STS  = 4'h4;
  localparam logic [3:0] OPC_LDCS = 4'h8;
  localparam logic [3:0] OPC_STCS = 4'hC;
  localparam logic [7:0] OP_KEY   = 8'hE0;

  localparam logic [3:0] CS_STATUSA        = 4'h0;
  localparam logic [3:0] CS_STATUSB        = 4'h1;
  localparam logic [3:0] CS_KEY_STATUS     = 4'h7;
  localparam logic [3:0] CS_ASI_RESET_REQ  = 4'h8;
  localparam logic [3:0] CS_ASI_SYS_STATUS = 4'hB;

  localparam logic [7:0] RESET_REQ_SIG = 8'h59;
  localparam logic [2:0] STATUSB_ERR   = 3'd3;

  // 64-bit key values; byte 0 (the LSB) is the first one on the wire.
  localparam logic [63:0] KEY_NVMPROG  = 64'h4E564D50726F6720; // "NVMProg "
  localparam logic [63:0] KEY_NVMERASE = 64'h4E564D4572617365; // "NVMErase"
  localparam int KEY_PROG_BIT  = 4;
  localparam int KEY_ERASE_BIT = 3;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_OPCODE,
    ST_ADDR,
    ST_MEM_RD,
    ST_RD_WAIT,
    ST_DATA_TX,
    ST_ACK_TX,
    ST_DATA_RX,
    ST_MEM_WR,
    ST_CS_TX,
    ST_CS_RX,
    ST_KEY_RX,
    ST_ERROR
  } state_t;

  // Select wire-order byte idx of a 64-bit key.
  function automatic logic [7:0] key_byte(input logic [63:0] k, input logic [2:0] idx);
    return k[{idx, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/updi_target_cs_regs.sv
// 16x8 UPDI control/status register file with read-only masks, STATUSB error flag and reset-request decode.
// Latency: writes visible the cycle after wr_en; reads and sys_rst_req are combinational from the registers.
// Backpressure: none; every strobe is accepted in the cycle it is presented.
module updi_target_cs_regs
  import updi_target_pkg::*;
#(
  parameter logic [7:0] STATUSA_RESET = 8'h30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] rd_addr,
  output logic [7:0] rd_data,
  input  logic       wr_en,
  input  logic [3:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic       err_set,
  input  logic       brk_clr,
  input  logic [7:0] key_set,
  output logic       sys_rst_req
);

  logic [7:0] cs_q [16];
  logic [7:0] cs_d [16];

  // Next register values: host write, key results, erase latch on reset request, error flag, break clear.
  always_comb begin
    for (int i = 0; i < 16; i++) cs_d[i] = cs_q[i];
    if (wr_en && (wr_addr != CS_STATUSA) && (wr_addr != CS_KEY_STATUS)) cs_d[wr_addr] = wr_data;
    if (wr_en && (wr_addr == CS_ASI_RESET_REQ) && (wr_data == RESET_REQ_SIG) &&
        cs_q[CS_KEY_STATUS][KEY_ERASE_BIT])
      cs_d[CS_ASI_SYS_STATUS][0] = 1'b1;
    cs_d[CS_KEY_STATUS] = cs_q[CS_KEY_STATUS] | key_set;
    if (err_set) cs_d[CS_STATUSB][2:0] = STATUSB_ERR;
    if (brk_clr) cs_d[CS_STATUSB] = 8'h00;
  end

  // Register file storage; only STATUSA has a non-zero reset value.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) cs_q[i] <= 8'h00;
      cs_q[CS_STATUSA] <= STATUSA_RESET;
    end else begin
      for (int i = 0; i < 16; i++) cs_q[i] <= cs_d[i];
    end
  end

  assign rd_data     = cs_q[rd_addr];
  assign sys_rst_req = (cs_q[CS_ASI_RESET_REQ] == RESET_REQ_SIG);

endmodule

// File: rtl/updi_target_responder.sv
// Device-side UPDI responder: decodes SYNCH+opcode from the RX FIFO, services LDCS/STCS/LDS/STS/KEY, bridges to a byte bus.
// Latency: 2 clks per RX byte (pop, then consume); LDCS reply pushed 1 clk after the opcode byte is consumed.
// Backpressure: pops only when RX is non-empty; stalls in push states while tx_full. Optional key check: UPDI_TARGET_KEY_EN.
module updi_target_responder
  import updi_target_pkg::*;
#(
  parameter logic [7:0] STATUSA_RESET = 8'h30,
  parameter int         KEY_BYTES     = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        break_detected,
  input  logic [7:0]  rx_data,
  output logic        rx_rd_en,
  input  logic        rx_empty,
  output logic [7:0]  tx_data,
  output logic        tx_wr_en,
  input  logic        tx_full,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_we,
  output logic        mem_re,
  input  logic [7:0]  mem_rdata,
  output logic        sys_rst_req,
  output logic        busy
);

  state_t      state_q, state_d;
  logic        rx_pend_q, rx_pend_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  wd0_q, wd0_d, wd1_q, wd1_d;
  logic [7:0]  tx_dat_q, tx_dat_d;
  logic [3:0]  cs_addr_q, cs_addr_d;
  logic        is_st_q, is_st_d;
  logic        as_q, as_d;
  logic        ds_q, ds_d;
  logic        wr_done_q, wr_done_d;
`ifdef UPDI_TARGET_KEY_EN
  logic        kprog_q, kprog_d;
  logic        kerase_q, kerase_d;
`endif

  logic        want_rx, push_st, byte_vld, last_data;
  logic        cs_we, err_set;
  logic [7:0]  key_set, cs_rdata;

  // Handshake strobes derive from the registered state; break and reset kill them in the same cycle.
  always_comb begin
    want_rx  = (state_q == ST_IDLE) || (state_q == ST_OPCODE) || (state_q == ST_ADDR) ||
               (state_q == ST_DATA_RX) || (state_q == ST_CS_RX) || (state_q == ST_KEY_RX) ||
               (state_q == ST_ERROR);
    push_st  = (state_q == ST_CS_TX) || (state_q == ST_DATA_TX) || (state_q == ST_ACK_TX);
    byte_vld = rx_pend_q;
    rx_rd_en = !rst && !break_detected && want_rx && !rx_pend_q && !rx_empty;
    tx_wr_en = !rst && !break_detected && push_st && !tx_full;
    mem_we   = !rst && !break_detected && (state_q == ST_MEM_WR);
    mem_re   = !rst && !break_detected && (state_q == ST_MEM_RD);
  end

  assign last_data = (cnt_q[0] == ds_q);
  assign mem_addr  = addr_q + {15'd0, cnt_q[0]};
  assign mem_wdata = cnt_q[0] ? wd1_q : wd0_q;
  assign tx_data   = tx_dat_q;
  assign busy      = (state_q != ST_IDLE);

  // Instruction sequencer: next state and datapath captures; break overrides everything.
  always_comb begin
    state_d   = state_q;
    rx_pend_d = rx_rd_en;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wd0_d     = wd0_q;
    wd1_d     = wd1_q;
    tx_dat_d  = tx_dat_q;
    cs_addr_d = cs_addr_q;
    is_st_d   = is_st_q;
    as_d      = as_q;
    ds_d      = ds_q;
    wr_done_d = wr_done_q;
    cs_we     = 1'b0;
    err_set   = 1'b0;
    key_set   = 8'h00;
`ifdef UPDI_TARGET_KEY_EN
    kprog_d   = kprog_q;
    kerase_d  = kerase_q;
`endif
    case (state_q)
      ST_IDLE: if (byte_vld && (rx_data == SYNCH)) state_d = ST_OPCODE;
      ST_OPCODE: if (byte_vld) begin
        cs_addr_d = rx_data[3:0];
        is_st_d   = rx_data[6];
        as_d      = rx_data[2];
        ds_d      = rx_data[0];
        cnt_d     = 4'd0;
        wr_done_d = 1'b0;
        if (rx_data[7:4] == OPC_LDCS) begin
          tx_dat_d = cs_rdata;
          state_d  = ST_CS_TX;
        end else if (rx_data[7:4] == OPC_STCS) begin
          state_d = ST_CS_RX;
        end else if (((rx_data[7:4] == OPC_LDS) || (rx_data[7:4] == OPC_STS)) &&
                     !rx_data[3] && !rx_data[1]) begin
          state_d = ST_ADDR;
        end else if (rx_data == OP_KEY) begin
`ifdef UPDI_TARGET_KEY_EN
          kprog_d  = 1'b1;
          kerase_d = 1'b1;
`endif
          state_d = ST_KEY_RX;
        end else begin
          err_set = 1'b1;
          state_d = ST_ERROR;
        end
      end
      ST_ADDR: if (byte_vld) begin
        if (cnt_q[0]) addr_d[15:8] = rx_data;
        else          addr_d       = {8'h00, rx_data};
        if (cnt_q[0] == as_q) begin
          cnt_d = 4'd0;
          if (is_st_q) begin
            tx_dat_d = ACK;
            state_d  = ST_ACK_TX;
          end else begin
            state_d = ST_MEM_RD;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_MEM_RD:  state_d = ST_RD_WAIT;
      ST_RD_WAIT: begin
        tx_dat_d = mem_rdata;
        state_d  = ST_DATA_TX;
      end
      ST_DATA_TX: if (tx_wr_en) begin
        if (last_data) state_d = ST_IDLE;
        else begin
          cnt_d   = cnt_q + 4'd1;
          state_d = ST_MEM_RD;
        end
      end
      ST_ACK_TX: if (tx_wr_en) state_d = wr_done_q ? ST_IDLE : ST_DATA_RX;
      ST_DATA_RX: if (byte_vld) begin
        if (cnt_q[0]) wd1_d = rx_data;
        else          wd0_d = rx_data;
        if (last_data) begin
          cnt_d   = 4'd0;
          state_d = ST_MEM_WR;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_MEM_WR: begin
        if (last_data) begin
          wr_done_d = 1'b1;
          tx_dat_d  = ACK;
          state_d   = ST_ACK_TX;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_CS_TX: if (tx_wr_en) state_d = ST_IDLE;
      ST_CS_RX: if (byte_vld) begin
        cs_we   = 1'b1;
        state_d = ST_IDLE;
      end
      ST_KEY_RX: if (byte_vld) begin
`ifdef UPDI_TARGET_KEY_EN
        kprog_d  = kprog_q  && (rx_data == key_byte(KEY_NVMPROG,  cnt_q[2:0]));
        kerase_d = kerase_q && (rx_data == key_byte(KEY_NVMERASE, cnt_q[2:0]));
`endif
        if (cnt_q == 4'(KEY_BYTES - 1)) begin
`ifdef UPDI_TARGET_KEY_EN
          key_set[KEY_PROG_BIT]  = kprog_d;
          key_set[KEY_ERASE_BIT] = kerase_d;
`endif
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_ERROR: state_d = ST_ERROR;
      default:  state_d = ST_IDLE;
    endcase
    if (break_detected) begin
      state_d = ST_IDLE;
      cs_we   = 1'b0;
      err_set = 1'b0;
      key_set = 8'h00;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      rx_pend_q <= 1'b0;
      cnt_q     <= 4'd0;
      addr_q    <= 16'h0000;
      wd0_q     <= 8'h00;
      wd1_q     <= 8'h00;
      tx_dat_q  <= 8'h00;
      cs_addr_q <= 4'h0;
      is_st_q   <= 1'b0;
      as_q      <= 1'b0;
      ds_q      <= 1'b0;
      wr_done_q <= 1'b0;
`ifdef UPDI_TARGET_KEY_EN
      kprog_q   <= 1'b0;
      kerase_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      rx_pend_q <= rx_pend_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wd0_q     <= wd0_d;
      wd1_q     <= wd1_d;
      tx_dat_q  <= tx_dat_d;
      cs_addr_q <= cs_addr_d;
      is_st_q   <= is_st_d;
      as_q      <= as_d;
      ds_q      <= ds_d;
      wr_done_q <= wr_done_d;
`ifdef UPDI_TARGET_KEY_EN
      kprog_q   <= kprog_d;
      kerase_q  <= kerase_d;
`endif
    end
  end

  updi_target_cs_regs #(
    .STATUSA_RESET(STATUSA_RESET)
  ) u_cs_regs (
    .clk        (clk),
    .rst        (rst),
    .rd_addr    (rx_data[3:0]),
    .rd_data    (cs_rdata),
    .wr_en      (cs_we),
    .wr_addr    (cs_addr_q),
    .wr_data    (rx_data),
    .err_set    (err_set),
    .brk_clr    (break_detected),
    .key_set    (key_set),
    .sys_rst_req(sys_rst_req)
  );

endmodule
